// File: rtl/wb_spi_mem.sv
// wb_spi_mem: Wishbone classic responder backed by a serial SPI SRAM.
// One SPI transaction (opcode, address, data) per bus cycle, mode 0,
// MSB first. The block generates its own ack once the transfer ends.
module wb_spi_mem #(
    parameter int unsigned AW        = 16,
    parameter logic [7:0]  CMD_READ  = 8'h03,
    parameter logic [7:0]  CMD_WRITE = 8'h02
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_spi_sck,
    output logic        o_spi_cs_n,
    output logic        o_spi_mosi,
    input  logic        i_spi_miso
);

    // Full outgoing frame: opcode, address, up to four data bytes.
    localparam int unsigned SW = 8 + AW + 32;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        DONE
    } state_t;

    state_t         state_q;
    logic           phase_q;
    logic [5:0]     cnt_q;
    logic [5:0]     dbits_q;
    logic           we_q;
    logic [SW-1:0]  sr_q;
    logic [31:0]    rx_q;
    logic [31:0]    rdt_q;
    logic           ack_q;
    logic           sck_q;
    logic           cs_n_q;
    logic           mosi_q;

    logic [1:0]     lo_c;
    logic [1:0]     hi_c;
    logic [1:0]     off_c;
    logic [2:0]     nbytes_c;
    logic [31:0]    shifted_c;
    logic [31:0]    data_c;
    logic [AW-1:0]  addr_c;
    logic [SW-1:0]  load_c;
    logic           unused_c;

    assign unused_c = ^{i_wb_adr[31:AW], i_wb_adr[1:0]};

    // Byte span of the request and the frame to shift out on a start.
    always_comb begin
        lo_c = '0;
        hi_c = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i_wb_sel[3 - i]) lo_c = 2'(3 - i);
            if (i_wb_sel[i])     hi_c = 2'(i);
        end
        if (i_wb_we) begin
            nbytes_c = {1'b0, hi_c} - {1'b0, lo_c} + 3'd1;
            off_c    = lo_c;
        end else begin
            nbytes_c = 3'd4;
            off_c    = 2'd0;
        end
        shifted_c = i_wb_dat >> {off_c, 3'b000};
        // Lowest-address byte goes out first, so it sits at the MSB end.
        if (i_wb_we)
            data_c = {shifted_c[7:0], shifted_c[15:8], shifted_c[23:16], shifted_c[31:24]};
        else
            data_c = '0;
        addr_c = {i_wb_adr[AW-1:2], off_c};
        load_c = {(i_wb_we ? CMD_WRITE : CMD_READ), addr_c, data_c};
    end

    // Transaction FSM with registered bus and SPI outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            dbits_q <= '0;
            we_q    <= 1'b0;
            sr_q    <= '0;
            rx_q    <= '0;
            rdt_q   <= '0;
            ack_q   <= 1'b0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_wb_cyc && !ack_q) begin
                        we_q    <= i_wb_we;
                        sr_q    <= load_c;
                        phase_q <= 1'b0;
                        cnt_q   <= 6'd7;
                        dbits_q <= {nbytes_c, 3'b000} - 6'd1;
                        if (i_wb_we && (i_wb_sel == 4'b0000)) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= CMD;
                            cs_n_q  <= 1'b0;
                            mosi_q  <= load_c[SW-1];
                        end
                    end
                end
                CMD, ADDR, DATA: begin
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                        sck_q   <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        sck_q   <= 1'b0;
                        sr_q    <= {sr_q[SW-2:0], 1'b0};
                        mosi_q  <= sr_q[SW-2];
                        if (state_q == DATA)
                            rx_q <= {rx_q[30:0], i_spi_miso};
                        if (cnt_q == '0) begin
                            case (state_q)
                                CMD: begin
                                    state_q <= ADDR;
                                    cnt_q   <= 6'(AW - 1);
                                end
                                ADDR: begin
                                    state_q <= DATA;
                                    cnt_q   <= dbits_q;
                                end
                                default: begin
                                    state_q <= DONE;
                                    cs_n_q  <= 1'b1;
                                    mosi_q  <= 1'b0;
                                end
                            endcase
                        end else begin
                            cnt_q <= cnt_q - 6'd1;
                        end
                    end
                end
                DONE: begin
                    // Ack only if the master is still waiting for it.
                    ack_q   <= i_wb_cyc;
                    state_q <= IDLE;
                    if (!we_q)
                        rdt_q <= {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_wb_rdt   = rdt_q;
    assign o_wb_ack   = ack_q;
    assign o_spi_sck  = sck_q;
    assign o_spi_cs_n = cs_n_q;
    assign o_spi_mosi = mosi_q;

endmodule

// File: doc/wb_spi_mem.md
Name: wb_spi_mem

Overview:
- Wishbone classic responder that serves the CPU memory port from an external serial SPI SRAM (23LC512-class, 16- or 24-bit addressing).
- Sits on the memory-side bus (adr/dat/sel/we/cyc in, rdt out) and produces its own ack after the SPI transfer completes.
- The interconnect forwards this ack to the CPU in place of its fixed single-cycle ack.
- Single SPI master, mode 0, MSB first, one transaction per bus cycle.

Parameters:
- AW, 16, SPI address width in bits; legal values 16 or 24.
- CMD_READ, 8'h03, SPI read opcode.
- CMD_WRITE, 8'h02, SPI write opcode.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_wb_adr  in  32  byte address; bits [AW-1:2] used, rest ignored.
- i_wb_dat  in  32  write data, little-endian byte lanes.
- i_wb_sel  in  4  byte enables.
- i_wb_we  in  1  1 = write, 0 = read.
- i_wb_cyc  in  1  cycle request (cyc and stb combined).
- o_wb_rdt  out  32  read data; valid while o_wb_ack is high after a read.
- o_wb_ack  out  1  one-cycle completion pulse.
- o_spi_sck  out  1  SPI clock, idles low.
- o_spi_cs_n  out  1  SPI chip select, active low.
- o_spi_mosi  out  1  SPI data out.
- i_spi_miso  in  1  SPI data in.

Behaviour:
- Reset (async assert, sync-safe release): state IDLE, o_wb_ack=0, o_wb_rdt=0, o_spi_cs_n=1, o_spi_sck=0, o_spi_mosi=0.
- States: IDLE -> CMD (8 bits) -> ADDR (AW bits) -> DATA (8*nbytes bits) -> DONE -> IDLE.
- Start condition: edge E0 where state is IDLE, i_wb_cyc=1 and o_wb_ack=0.
- At E0, latch adr/dat/sel/we and compute:
  - Reads: nbytes=4, byte offset 0.
  - Writes: lo = lowest set sel bit, hi = highest set sel bit, nbytes = hi-lo+1, offset = lo. Lanes between lo and hi are written even if their sel bit is clear.
- SPI address = {i_wb_adr[AW-1:2], offset[1:0]}, sent MSB first.
- o_spi_cs_n goes low at E0. It must not go low again until at least one full cycle after it returns high.
- Each bit takes two i_clk cycles:
  - Phase 0: o_spi_sck=0, o_spi_mosi driven.
  - Phase 1: o_spi_sck=1.
  - i_spi_miso is sampled at the edge that ends phase 1.
- Byte order: lowest address byte first. Write byte k (k = 0..nbytes-1) = i_wb_dat[8*(offset+k)+:8], MSB first. Read byte k fills o_wb_rdt[8k+:8], MSB first.
- o_spi_mosi is 0 during read data bits.
- Let N = 8 + AW + 8*nbytes. After the last bit's phase 1, state DONE:
  - o_spi_cs_n=1 and o_spi_sck=0.
  - o_wb_ack=1 for exactly one cycle, 2N+1 cycles after E0 (AW=16: word read/write 113, byte write 65, halfword write 81).
- o_wb_rdt updates only on read completion. It holds its value through and after the ack until the next read completes.
- Write with sel=4'b0000: no SPI activity (cs_n stays high); ack at E0+1.
- i_wb_cyc deasserted mid-transaction: the SPI transfer completes normally, ack is suppressed, and the block returns to IDLE.
- i_wb_cyc held high after ack: the ack-low cycle gates restart, so the next transaction starts at ack+1 edge. The new transaction uses the inputs present at that edge.
- Reset asserted mid-transfer: outputs return immediately to reset values; no ack is issued.
- No pipelining, no retry, no error response.

Test Plan:
- Reset: hold i_rst_n=0 with i_wb_cyc=1 -> cs_n=1, sck=0, ack=0, rdt=0; no SPI edges for 200 cycles.
- Word read at adr 0x0000_1234, SPI model returns bytes 0xDD,0xCC,0xBB,0xAA -> MOSI carries 0x03, 0x1234 (16 bits); rdt=0xAABBCCDD; ack exactly at E0+113; 56 sck rising edges.
- Byte write adr 0x0000_0040, sel=4'b0100, dat=0x00EF0000 -> MOSI carries 0x02, 0x0042, 0xEF; ack at E0+65; rdt unchanged.
- Halfword write adr 0x10, sel=4'b1100, dat=0xBEEF0000 -> address 0x0012, bytes 0xEF,0xBE; ack at E0+81; then a word read of 0x10 returns 0xBEEFxxxx.
- Write with sel=0 -> ack at E0+1, cs_n never low; reset pulse at cycle 40 of a read -> cs_n high the same cycle, no ack; the next read completes normally.
- Back-to-back: cyc held high across two reads -> second cs_n fall at least 1 cycle after the first cs_n rise; each ack is exactly one cycle wide.
